cmd_seq_multi: RTL and testbench

Parametrised multi-channel command sequencer for the MultiIO FPGA, successor to the single-channel FE command sequencer. It sits on the 8-bit USB-side register bus and serialises a byte pattern held in internal memory, MSB first, onto up to eight FE command lines. Over the single-channel block it adds:
- per-channel output enables;
- a programmable inter-pass wait;
- continuous mode with a stop register;
- an optional external start.

---
 rtl/cmd_seq_multi.sv | 287 ++++++++++++++++++++++++++++
 tb/tb_cmd_seq_multi.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmd_seq_multi.sv
// cmd_seq_multi: multi-channel command sequencer on the 8-bit register bus.
// Serialises a byte pattern from internal memory, MSB first, onto up to eight
// command lines, with repeat count, inter-pass wait, continuous mode with a
// stop register and per-channel output enables.
//
// Optional feature macro: CMD_SEQ_EXT_START_EN
//   defined   - EXT_START starts a run when CONF[0]=1; CONF[0] is read/write.
//   undefined - EXT_START is ignored; CONF[0] reads 0.
//
// Ports:
//   BUS_CLK        single clock for bus, sequencer and outputs
//   BUS_RST_B      asynchronous active-low reset
//   BUS_ADD        bus address
//   BUS_DATA_IN    write data
//   BUS_DATA_OUT   read data, valid one cycle after BUS_RD
//   BUS_RD/BUS_WR  one-cycle read/write strobes
//   EXT_START      external start pulse (synchronous)
//   CMD_DATA       serial command bits, one per channel
//   CMD_READY      sequencer idle
//   CMD_START_FLAG one-cycle pulse with the first bit of every pass
module cmd_seq_multi #(
  parameter logic [15:0] BASEADDR  = 16'h0000,
  parameter int unsigned MEM_BYTES = 2048,
  parameter int unsigned CHANNELS  = 4
) (
  input  logic                BUS_CLK,
  input  logic                BUS_RST_B,
  input  logic [15:0]         BUS_ADD,
  input  logic [7:0]          BUS_DATA_IN,
  output logic [7:0]          BUS_DATA_OUT,
  input  logic                BUS_RD,
  input  logic                BUS_WR,
  input  logic                EXT_START,
  output logic [CHANNELS-1:0] CMD_DATA,
  output logic                CMD_READY,
  output logic                CMD_START_FLAG
);

  localparam int unsigned AW       = $clog2(MEM_BYTES);
  localparam int unsigned MEM_BITS = MEM_BYTES * 8;
  localparam int unsigned MEM_END  = 16 + MEM_BYTES;

  typedef enum logic [1:0] {S_IDLE, S_PRE, S_RUN, S_WAIT} state_t;

  state_t              r_state;
  logic [15:0]         r_size;
  logic [15:0]         r_repeat;
  logic [15:0]         r_wait;
  logic [15:0]         r_bit;     // index of the bit shown at the next edge
  logic [15:0]         r_pass;    // passes started in this run
  logic [15:0]         r_wcnt;
  logic [CHANNELS-1:0] r_oen;
  logic                r_end;     // bit currently on CMD_DATA is the last of its pass
  logic                r_stop;
  logic [CHANNELS-1:0] r_cmd;
  logic                r_ready;
  logic                r_flag;

  logic [7:0]          r_mem [MEM_BYTES];
  logic [7:0]          r_seq_byte;
  logic [7:0]          r_mem_rdata;
  logic [7:0]          r_reg_rdata;
  logic                r_rd_mem;

  logic [15:0]         w_off;
  logic                w_mem_hit;
  logic [AW-1:0]       w_mem_idx;
  logic                w_idle;
  logic                w_soft_rst;
  logic                w_start_wr;
  logic                w_stop_wr;
  logic                w_mem_we;
  logic                w_ext;
  logic                w_conf;
  logic                w_start;
  logic [15:0]         w_size_eff;
  logic                w_last;
  logic                w_cont;
  logic                w_show;
  logic [15:0]         w_bit_nxt;
  logic [AW-1:0]       w_rd_addr;
  logic                w_bit_val;
  logic [7:0]          w_reg_rd;

  // Address decode relative to the block base
  assign w_off      = BUS_ADD - BASEADDR;
  assign w_mem_hit  = (w_off >= 16'd16) && (17'(w_off) < 17'(MEM_END));
  assign w_mem_idx  = AW'(w_off - 16'd16);
  assign w_idle     = (r_state == S_IDLE);
  assign w_soft_rst = BUS_WR && (w_off == 16'd0);
  assign w_start_wr = BUS_WR && (w_off == 16'd1);
  assign w_stop_wr  = BUS_WR && (w_off == 16'd2);
  assign w_mem_we   = BUS_WR && w_mem_hit && w_idle;

`ifdef CMD_SEQ_EXT_START_EN
  logic r_conf;

  // CONF register: EXT_START enable, writable in any state
  always_ff @(posedge BUS_CLK or negedge BUS_RST_B) begin
    if (!BUS_RST_B) begin
      r_conf <= 1'b0;
    end else if (w_soft_rst) begin
      r_conf <= 1'b0;
    end else if (BUS_WR && (w_off == 16'd10)) begin
      r_conf <= BUS_DATA_IN[0];
    end
  end

  assign w_conf = r_conf;
  assign w_ext  = EXT_START && r_conf;
`else
  logic w_unused_ext;
  assign w_unused_ext = EXT_START;
  assign w_conf       = 1'b0;
  assign w_ext        = 1'b0;
`endif

  // A start write and EXT_START on the same cycle collapse into one start
  assign w_start = w_idle && (r_size != 16'd0) && (w_start_wr || w_ext);

  // 17-bit compare: MEM_BITS can be 65536 for the largest memory
  assign w_size_eff = (17'(r_size) > 17'(MEM_BITS)) ? 16'(MEM_BITS) : r_size;
  assign w_last     = (r_bit == (w_size_eff - 16'd1));
  assign w_cont     = !r_stop && ((r_repeat == 16'd0) || (r_pass != r_repeat));

  // Whether a pattern bit goes onto CMD_DATA at the coming edge
  always_comb begin
    w_show = 1'b0;
    case (r_state)
      S_PRE:   w_show = 1'b1;
      S_RUN:   w_show = !r_end || (w_cont && (r_wait == 16'd0));
      S_WAIT:  w_show = !r_stop && (r_wcnt == r_wait);
      default: w_show = 1'b0;
    endcase
  end

  // Prefetch: the byte holding the next bit is read one edge ahead
  assign w_bit_nxt = w_show ? (w_last ? 16'd0 : (r_bit + 16'd1)) : 16'd0;
  assign w_rd_addr = w_bit_nxt[AW+2:3];
  assign w_bit_val = r_seq_byte[3'd7 - r_bit[2:0]];

  // Pattern memory: bus write port, sequencer and bus synchronous read ports
  always_ff @(posedge BUS_CLK) begin
    if (w_mem_we) begin
      r_mem[w_mem_idx] <= BUS_DATA_IN;
    end
    r_seq_byte <= r_mem[w_rd_addr];
    if (BUS_RD) begin
      r_mem_rdata <= r_mem[w_mem_idx];
    end
  end

  // Register read mux
  always_comb begin
    w_reg_rd = 8'h00;
    case (w_off)
      16'd1:   w_reg_rd = {7'b0, r_ready};
      16'd3:   w_reg_rd = r_size[7:0];
      16'd4:   w_reg_rd = r_size[15:8];
      16'd5:   w_reg_rd = r_repeat[7:0];
      16'd6:   w_reg_rd = r_repeat[15:8];
      16'd7:   w_reg_rd = r_wait[7:0];
      16'd8:   w_reg_rd = r_wait[15:8];
      16'd9:   w_reg_rd = 8'(r_oen);
      16'd10:  w_reg_rd = {7'b0, w_conf};
      default: w_reg_rd = 8'h00;
    endcase
  end

  // Bus read data register
  always_ff @(posedge BUS_CLK or negedge BUS_RST_B) begin
    if (!BUS_RST_B) begin
      r_reg_rdata <= 8'h00;
      r_rd_mem    <= 1'b0;
    end else if (BUS_RD) begin
      r_reg_rdata <= w_reg_rd;
      r_rd_mem    <= w_mem_hit;
    end
  end

  assign BUS_DATA_OUT = r_rd_mem ? r_mem_rdata : r_reg_rdata;

  // Configuration registers, sequencer FSM and registered outputs
  always_ff @(posedge BUS_CLK or negedge BUS_RST_B) begin
    if (!BUS_RST_B) begin
      r_state  <= S_IDLE;
      r_size   <= 16'd0;
      r_repeat <= 16'd1;
      r_wait   <= 16'd0;
      r_oen    <= '1;
      r_bit    <= 16'd0;
      r_pass   <= 16'd0;
      r_wcnt   <= 16'd0;
      r_end    <= 1'b0;
      r_stop   <= 1'b0;
      r_cmd    <= '0;
      r_ready  <= 1'b1;
      r_flag   <= 1'b0;
    end else if (w_soft_rst) begin
      r_state  <= S_IDLE;
      r_size   <= 16'd0;
      r_repeat <= 16'd1;
      r_wait   <= 16'd0;
      r_oen    <= '1;
      r_bit    <= 16'd0;
      r_pass   <= 16'd0;
      r_wcnt   <= 16'd0;
      r_end    <= 1'b0;
      r_stop   <= 1'b0;
      r_cmd    <= '0;
      r_ready  <= 1'b1;
      r_flag   <= 1'b0;
    end else begin
      // Run parameters are frozen while a run is active
      if (w_idle && BUS_WR) begin
        case (w_off)
          16'd3:   r_size[7:0]    <= BUS_DATA_IN;
          16'd4:   r_size[15:8]   <= BUS_DATA_IN;
          16'd5:   r_repeat[7:0]  <= BUS_DATA_IN;
          16'd6:   r_repeat[15:8] <= BUS_DATA_IN;
          16'd7:   r_wait[7:0]    <= BUS_DATA_IN;
          16'd8:   r_wait[15:8]   <= BUS_DATA_IN;
          default: ;
        endcase
      end
      if (BUS_WR && (w_off == 16'd9)) begin
        r_oen <= BUS_DATA_IN[CHANNELS-1:0];
      end
      if (w_stop_wr && !w_idle) begin
        r_stop <= 1'b1;
      end

      r_bit  <= w_bit_nxt;
      r_end  <= w_show && w_last;
      r_flag <= w_show && (r_bit == 16'd0);
      r_cmd  <= w_show ? ({CHANNELS{w_bit_val}} & r_oen) : '0;
      if (w_show && (r_bit == 16'd0)) begin
        r_pass <= r_pass + 16'd1;
      end

      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_state <= S_PRE;
            r_ready <= 1'b0;
            r_pass  <= 16'd0;
            r_stop  <= 1'b0;
          end
        end
        S_PRE: begin
          r_state <= S_RUN;
        end
        S_RUN: begin
          // End of pass without a back-to-back continuation
          if (r_end && !w_show) begin
            if (w_cont) begin
              r_state <= S_WAIT;
              r_wcnt  <= 16'd1;
            end else begin
              r_state <= S_IDLE;
              r_ready <= 1'b1;
            end
          end
        end
        S_WAIT: begin
          if (r_stop) begin
            r_state <= S_IDLE;
            r_ready <= 1'b1;
          end else if (w_show) begin
            r_state <= S_RUN;
          end else begin
            r_wcnt <= r_wcnt + 16'd1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  assign CMD_DATA       = r_cmd;
  assign CMD_READY      = r_ready;
  assign CMD_START_FLAG = r_flag;

endmodule

// File: tb/tb_cmd_seq_multi.sv
// Self-checking bench for cmd_seq_multi: directed steps plus randomized runs,
// compared cycle by cycle against a pattern-stream model.
module tb_cmd_seq_multi;

  localparam logic [15:0] BASE = 16'h1000;
  localparam int unsigned MEMB = 32;
  localparam int unsigned CH   = 4;

  logic          clk = 1'b0;
  logic          rst_b;
  logic [15:0]   add;
  logic [7:0]    din;
  logic [7:0]    dout;
  logic          rd;
  logic          wr;
  logic          ext;
  logic [CH-1:0] cmd;
  logic          ready;
  logic          flag;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cmd_seq_multi #(.BASEADDR(BASE), .MEM_BYTES(MEMB), .CHANNELS(CH)) dut (
    .BUS_CLK        (clk),
    .BUS_RST_B      (rst_b),
    .BUS_ADD        (add),
    .BUS_DATA_IN    (din),
    .BUS_DATA_OUT   (dout),
    .BUS_RD         (rd),
    .BUS_WR         (wr),
    .EXT_START      (ext),
    .CMD_DATA       (cmd),
    .CMD_READY      (ready),
    .CMD_START_FLAG (flag)
  );

  typedef struct packed {
    logic [CH-1:0] d;
    logic          f;
    logic          r;
  } obs_t;

  logic [7:0]    m_mem [MEMB];
  int            m_size;
  int            m_rep;
  int            m_wait;
  logic [CH-1:0] m_oen;
  obs_t          exp_q[$];
  logic [7:0]    inj_byte;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic bus_write(input int off, input logic [7:0] data);
    add = BASE + 16'(off);
    din = data;
    wr  = 1'b1;
    step();
    wr  = 1'b0;
  endtask

  task automatic bus_read(input int off, output logic [7:0] data);
    add = BASE + 16'(off);
    rd  = 1'b1;
    step();
    rd  = 1'b0;
    data = dout;
  endtask

  task automatic read_check(input string tag, input int off, input logic [7:0] expv);
    logic [7:0] v;
    bus_read(off, v);
    check(tag, 32'(v), 32'(expv));
  endtask

  task automatic set_cfg(input int size, input int rep, input int wt, input logic [CH-1:0] oen);
    bus_write(3, 8'(size));
    bus_write(4, 8'(size >> 8));
    bus_write(5, 8'(rep));
    bus_write(6, 8'(rep >> 8));
    bus_write(7, 8'(wt));
    bus_write(8, 8'(wt >> 8));
    bus_write(9, 8'(oen));
    m_size = size;
    m_rep  = rep;
    m_wait = wt;
    m_oen  = oen;
  endtask

  task automatic mem_write(input int idx, input logic [7:0] v);
    bus_write(16 + idx, v);
    m_mem[idx] = v;
  endtask

  // Expected per-cycle stream starting the cycle after the start is sampled
  task automatic build(input int n_pass);
    int eff;
    logic [7:0] b;
    exp_q.delete();
    eff = (m_size > int'(MEMB * 8)) ? int'(MEMB * 8) : m_size;
    exp_q.push_back({{CH{1'b0}}, 1'b0, 1'b0});
    for (int p = 0; p < n_pass; p++) begin
      for (int k = 0; k < eff; k++) begin
        b = m_mem[k / 8];
        exp_q.push_back({b[7 - (k % 8)] ? m_oen : {CH{1'b0}}, (k == 0), 1'b0});
      end
      if (p < n_pass - 1) begin
        for (int w = 0; w < m_wait; w++) exp_q.push_back({{CH{1'b0}}, 1'b0, 1'b0});
      end
    end
    exp_q.push_back({{CH{1'b0}}, 1'b0, 1'b1});
    exp_q.push_back({{CH{1'b0}}, 1'b0, 1'b1});
  endtask

  task automatic idle_stream(input int n);
    exp_q.delete();
    for (int i = 0; i < n; i++) exp_q.push_back({{CH{1'b0}}, 1'b0, 1'b1});
  endtask

  // start_kind: 1 write, 2 EXT_START, 3 both.
  // inj_kind: 1 stop, 2 EXT_START, 3 start write, 4 soft reset, 5 memory write
  task automatic play(input string tag, input int start_kind, input int inj_at, input int inj_kind);
    obs_t got;
    add = BASE + 16'd1;
    din = 8'h00;
    if (start_kind != 2) wr = 1'b1;
    if (start_kind != 1) ext = 1'b1;
    for (int i = 0; i < exp_q.size(); i++) begin
      step();
      wr  = 1'b0;
      ext = 1'b0;
      got = {cmd, flag, ready};
      check($sformatf("%s[%0d]", tag, i), 32'(got), 32'(exp_q[i]));
      if (i == inj_at) begin
        case (inj_kind)
          1: begin add = BASE + 16'd2; wr = 1'b1; end
          2: ext = 1'b1;
          3: begin add = BASE + 16'd1; wr = 1'b1; end
          4: begin add = BASE; wr = 1'b1; end
          5: begin add = BASE + 16'd16; din = inj_byte; wr = 1'b1; end
          default: ;
        endcase
      end
    end
    wr  = 1'b0;
    ext = 1'b0;
  endtask

  initial begin
    rst_b = 1'b0;
    add   = 16'h0000;
    din   = 8'h00;
    rd    = 1'b0;
    wr    = 1'b0;
    ext   = 1'b0;
    m_size = 0;
    m_rep  = 1;
    m_wait = 0;
    m_oen  = '1;
    inj_byte = 8'h00;
    step();
    step();

    // Reset values
    check("rst_cmd",   32'(cmd),   32'd0);
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_flag",  32'(flag),  32'd0);
    check("rst_dout",  32'(dout),  32'd0);
    rst_b = 1'b1;
    step();

    // Register reset values and decode
    read_check("rd_ready",  1,  8'h01);
    read_check("rd_size_l", 3,  8'h00);
    read_check("rd_size_h", 4,  8'h00);
    read_check("rd_rep_l",  5,  8'h01);
    read_check("rd_rep_h",  6,  8'h00);
    read_check("rd_wait_l", 7,  8'h00);
    read_check("rd_oen",    9,  8'h0F);
    read_check("rd_conf",   10, 8'h00);
    read_check("rd_hole",   11, 8'h00);
    bus_write(9, 8'hFF);
    read_check("rd_oen_mask", 9, 8'h0F);

    // Random pattern memory, read back
    for (int i = 0; i < int'(MEMB); i++) mem_write(i, 8'($urandom));
    read_check("rd_mem0", 16, m_mem[0]);
    read_check("rd_mem31", 16 + int'(MEMB) - 1, m_mem[MEMB-1]);

    // Five bits of 1110_1000
    mem_write(0, 8'b1110_1000);
    set_cfg(5, 1, 0, 4'hF);
    build(1);
    play("t5bit", 1, -1, 0);

    // Three 9-bit passes separated by four idle cycles
    mem_write(0, 8'hB1);
    mem_write(1, 8'h00);
    set_cfg(9, 3, 4, 4'hF);
    build(3);
    play("t3pass", 1, -1, 0);

    // Output enables mask channels 1 and 3
    mem_write(0, 8'hFF);
    set_cfg(8, 1, 0, 4'b0101);
    build(1);
    play("toen", 1, -1, 0);

    // SIZE=0 start is ignored
    set_cfg(0, 1, 0, 4'hF);
    idle_stream(8);
    play("tsize0", 1, -1, 0);

    // Continuous mode, stop written during the sixth pass
    for (int i = 0; i < 4; i++) mem_write(i, 8'($urandom));
    set_cfg(4, 0, 0, 4'hF);
    build(6);
    play("tstop", 1, 22, 1);

    // A stop while idle is not remembered; start during run is ignored
    bus_write(2, 8'h00);
    set_cfg(3, 2, 2, 4'hF);
    build(2);
    play("tstart_busy", 1, 3, 3);

    // Memory write during a run is ignored
    set_cfg(12, 1, 0, 4'hF);
    inj_byte = ~m_mem[0];
    build(1);
    play("tmem_busy", 1, 4, 5);
    read_check("rd_mem_kept", 16, m_mem[0]);

    // Randomized runs
    for (int n = 0; n < 5; n++) begin
      for (int i = 0; i < 6; i++) mem_write(i, 8'($urandom));
      set_cfg(int'($urandom_range(40, 1)), int'($urandom_range(3, 1)),
              int'($urandom_range(3, 0)), CH'($urandom));
      build(m_rep);
      play($sformatf("trand%0d", n), 1, -1, 0);
    end

    // SIZE larger than memory clamps to MEMB*8 bits
    set_cfg(300, 1, 0, 4'hF);
    build(1);
    play("tclamp", 1, -1, 0);

    // Soft reset while showing bit 7
    set_cfg(16, 1, 0, 4'hF);
    build(1);
    for (int j = 9; j < exp_q.size(); j++) exp_q[j] = {{CH{1'b0}}, 1'b0, 1'b1};
    while (exp_q.size() > 11) void'(exp_q.pop_back());
    play("tsoft", 1, 8, 4);
    m_size = 0; m_rep = 1; m_wait = 0; m_oen = '1;
    read_check("soft_size_l", 3, 8'h00);
    read_check("soft_size_h", 4, 8'h00);
    read_check("soft_rep_l",  5, 8'h01);
    read_check("soft_oen",    9, 8'h0F);
    read_check("soft_mem0",   16, m_mem[0]);
    read_check("soft_mem1",   17, m_mem[1]);

    // External start
    bus_write(10, 8'h01);
`ifdef CMD_SEQ_EXT_START_EN
    read_check("rd_conf_set", 10, 8'h01);
    set_cfg(8, 1, 0, 4'hF);
    build(1);
    play("text", 2, 4, 2);
    build(1);
    play("text_both", 3, -1, 0);
`else
    read_check("rd_conf_set", 10, 8'h00);
    set_cfg(8, 1, 0, 4'hF);
    idle_stream(12);
    play("text_off", 2, -1, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
